// File: rtl/ascon_ctrl_fsm.sv
// Control sequencer for one ASCON-128a encryption: init, one AD block,
// NB_PT_BLOCKS plaintext blocks and finalisation, driving permutation_xor.
module ascon_ctrl_fsm #(
  parameter int unsigned NB_PT_BLOCKS = 4
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       data_valid_i,
  output logic       data_ready_o,
  output logic [3:0] round_o,
  output logic       sel_mux_o,
  output logic       enable_o,
  output logic       ena_xor_up_o,
  output logic       ena_xor_key_up_o,
  output logic       ena_xor_down_o,
  output logic [1:0] sel_xor_down_o,
  output logic       cipher_valid_o,
  output logic       done_o
);

  localparam int unsigned RND_W = 4;
  localparam int unsigned BLK_W = 4;
  localparam logic [RND_W-1:0] LAST_RND  = RND_W'(11);
  localparam logic [RND_W-1:0] FIRST_P8  = RND_W'(4);
  localparam logic [BLK_W-1:0] LAST_BLK  = BLK_W'(NB_PT_BLOCKS - 1);
  localparam logic [1:0]       XD_KEY    = 2'd0;
  localparam logic [1:0]       XD_DOMAIN = 2'd1;

  typedef enum logic [3:0] {
    S_IDLE, S_CONF_INIT, S_INIT, S_WAIT_AD, S_AD,
    S_WAIT_PT, S_PT, S_FINAL, S_END
  } state_e;

  state_e           state_q, state_d;
  logic [RND_W-1:0] round_q, round_d;
  logic [BLK_W-1:0] blk_q, blk_d;

  // State, round counter and plaintext block counter
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      round_q <= '0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      blk_q   <= blk_d;
    end
  end

  // Next state and Mealy control outputs; accept cycles depend on data_valid_i
  always_comb begin
    state_d          = state_q;
    round_d          = round_q;
    blk_d            = blk_q;
    data_ready_o     = 1'b0;
    round_o          = '0;
    sel_mux_o        = 1'b0;
    enable_o         = 1'b0;
    ena_xor_up_o     = 1'b0;
    ena_xor_key_up_o = 1'b0;
    ena_xor_down_o   = 1'b0;
    sel_xor_down_o   = XD_KEY;
    cipher_valid_o   = 1'b0;
    done_o           = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        round_d = '0;
        blk_d   = '0;
        if (start_i) state_d = S_CONF_INIT;
      end

      S_CONF_INIT: begin
        enable_o = 1'b1;
        round_d  = RND_W'(1);
        state_d  = S_INIT;
      end

      S_INIT, S_AD, S_PT, S_FINAL: begin
        sel_mux_o = 1'b1;
        enable_o  = 1'b1;
        round_o   = round_q;
        if (round_q == LAST_RND) begin
          round_d = '0;
          unique case (state_q)
            S_INIT: begin
              ena_xor_down_o = 1'b1;
              state_d        = S_WAIT_AD;
            end
            S_AD: begin
              ena_xor_down_o = 1'b1;
              sel_xor_down_o = XD_DOMAIN;
              state_d        = S_WAIT_PT;
            end
            S_PT: begin
              blk_d   = blk_q + BLK_W'(1);
              state_d = S_WAIT_PT;
            end
            default: begin
              ena_xor_down_o = 1'b1;
              state_d        = S_END;
            end
          endcase
        end else begin
          round_d = round_q + RND_W'(1);
        end
      end

      S_WAIT_AD, S_WAIT_PT: begin
        data_ready_o = 1'b1;
        if (data_valid_i) begin
          enable_o     = 1'b1;
          sel_mux_o    = 1'b1;
          ena_xor_up_o = 1'b1;
          if (state_q == S_WAIT_AD) begin
            round_o = FIRST_P8;
            round_d = FIRST_P8 + RND_W'(1);
            state_d = S_AD;
          end else if (blk_q == LAST_BLK) begin
            // last plaintext block goes straight into the p^12 finalisation
            cipher_valid_o   = 1'b1;
            ena_xor_key_up_o = 1'b1;
            round_o          = '0;
            round_d          = RND_W'(1);
            state_d          = S_FINAL;
          end else begin
            cipher_valid_o = 1'b1;
            round_o        = FIRST_P8;
            round_d        = FIRST_P8 + RND_W'(1);
            state_d        = S_PT;
          end
        end
      end

      S_END: begin
        done_o  = 1'b1;
        round_d = '0;
        blk_d   = '0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        round_d = '0;
        blk_d   = '0;
      end
    endcase
  end

endmodule

// File: doc/ascon_ctrl_fsm.md
Name: ascon_ctrl_fsm

Overview:
- Control FSM directly upstream of permutation_xor for one ASCON-128a encryption: initialisation, one associated-data block, NB_PT_BLOCKS plaintext blocks, then finalisation.
- Generates every control input of permutation_xor: round counter, state-mux select, register write enable, XOR-up/XOR-down enables and XOR-down select.
- Handshakes 128-bit blocks with the data source and flags ciphertext and tag availability to the output stage.

Parameters:
- NB_PT_BLOCKS, 4, number of 128-bit plaintext blocks per message; legal range 1..15.

Ports:
- clock_i  in  1  system clock, rising edge.
- reset_i  in  1  synchronous, active-high reset.
- start_i  in  1  start one encryption; sampled only in IDLE.
- data_valid_i  in  1  data_i (AD or plaintext block) valid at the permutation_xor input.
- data_ready_o  out  1  controller can accept a block this cycle.
- round_o  out  4  round index to permutation_xor round_i.
- sel_mux_o  out  1  0 = load state_i, 1 = feed back registered state.
- enable_o  out  1  state register write enable.
- ena_xor_up_o  out  1  XOR data_i into S0:S1 before the round.
- ena_xor_key_up_o  out  1  additionally XOR key into S2:S3 before the round (finalisation entry).
- ena_xor_down_o  out  1  XOR after the round.
- sel_xor_down_o  out  2  0 = key into S3:S4; 1 = domain-separation bit into S4 LSB.
- cipher_valid_o  out  1  ciphertext (XOR-up result S0:S1) valid this cycle.
- done_o  out  1  1-cycle pulse: tag (state_o S3:S4) valid, encryption finished.

Behaviour:
- Reset: synchronous; state IDLE, all outputs 0, round_o = 0, block counter 0. Reset in any state aborts the operation; data_ready_o is 0 on the next cycle.
- States: IDLE, CONF_INIT, INIT, WAIT_AD, AD, WAIT_PT, PT, FINAL, END.
- Outputs are 0 unless stated below.
- IDLE: all outputs 0. start_i=1 -> CONF_INIT.
- CONF_INIT (1 cycle): sel_mux=0, enable=1, round=0 -> INIT.
- INIT: sel_mux=1, enable=1, round 1..11, incrementing each cycle.
  - At round 11: ena_xor_down=1, sel_xor_down=0 -> WAIT_AD.
- WAIT_AD / WAIT_PT: data_ready=1, enable=0, so the state is frozen indefinitely while data_valid_i=0.
- Accept cycle (Mealy, ready & valid):
  - Always: enable=1, sel_mux=1, ena_xor_up=1.
  - WAIT_AD: round=4 -> AD.
  - WAIT_PT, non-last block: round=4, cipher_valid=1 -> PT.
  - WAIT_PT, last block (counter = NB_PT_BLOCKS-1): round=0, ena_xor_key_up=1, cipher_valid=1 -> FINAL.
- AD: round 5..11. At round 11: ena_xor_down=1, sel_xor_down=1 -> WAIT_PT.
- PT: round 5..11. At round 11: increment block counter -> WAIT_PT.
- FINAL: round 1..11. At round 11: ena_xor_down=1, sel_xor_down=0 -> END.
- END (1 cycle): done=1, enable=0 -> IDLE; counters cleared.
- Intermediate permutations are p^8 (rounds 4..11); init and final permutations are p^12 (rounds 0..11).
- round_o is 4 bits and never exceeds 11; the 12 -> 0 wrap never occurs.
- start_i outside IDLE is ignored.
- data_valid_i outside WAIT states is ignored (data_ready=0).
- data_i must be held stable by the source only during the accept cycle.
- Latency without stalls, start sampled at cycle T: done at T+13+8+8*NB_PT_BLOCKS+4.

Test Plan:
- Reset held, then start_i=1 at T -> CONF_INIT at T+1 with sel_mux=0, round 0; rounds 1..11 at T+2..T+12; ena_xor_down=1, sel_xor_down=0 only at T+12; permutation_xor state matches the known-good post-init vector.
- Full message, NB_PT_BLOCKS=4, data_valid_i tied high -> data_ready/accept at T+13, T+21, T+29, T+37, T+45; cipher_valid at T+21, T+29, T+37, T+45; done exactly at T+57.
- data_valid_i low for 5 cycles in WAIT_PT -> enable=0 and state_o unchanged during the stall; done delayed by exactly 5 cycles.
- NB_PT_BLOCKS=1 -> first PT accept has round=0, ena_xor_key_up=1, no p^8 block; done at T+13+8+12 = T+33.
- reset_i asserted during PT round 7 -> next cycle all outputs 0 and round_o=0; a new start then completes with nominal latency.
- start_i pulsed during INIT and data_valid_i pulsed during AD -> no effect on the sequence or the timing.
